// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and imem (slave).
// Latency: request accepted the cycle it is raised; response returns >= 1 cycle later, in order.
// Backpressure: none on the port itself; the fetch stage throttles by withholding imem_req_out.
interface instruction_fetch_stage_if;
   logic        imem_req_out;
   logic [31:0] imem_addr_out;
   logic        imem_rvalid_in;
   logic [31:0] imem_rdata_in;

   modport master (
      output imem_req_out,
      output imem_addr_out,
      input  imem_rvalid_in,
      input  imem_rdata_in
   );

   modport slave (
      input  imem_req_out,
      input  imem_addr_out,
      output imem_rvalid_in,
      output imem_rdata_in
   );
endinterface

// File: rtl/instruction_fetch_stage.sv
// RV32 fetch stage plus IF/ID register: owns the fetch PC, one outstanding imem read, response FIFO.
// Latency: request at t, response at t+L, instruction on instr_out after edge t+L+1 (no bypass).
// Backpressure: stall_in holds IF/ID; requests stop once FIFO entries plus in-flight reach BUF_DEPTH.
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic                             stall_in,
   input  logic                             redirect_in,
   input  logic [31:0]                      redirect_pc_in,
   instruction_fetch_stage_if.master        imem,
   output logic [31:0]                      instr_out,
   output logic [31:0]                      pc_out,
   output logic                             flush_out
);

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          PW  = $clog2(BUF_DEPTH);
   localparam int          CW  = $clog2(BUF_DEPTH + 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic          outstanding_q, outstanding_d;
   logic          drop_q, drop_d;
   entry_t        fifo_q [BUF_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   pc_q, pc_d;
   logic          flush_q, flush_d;

   logic          pop;
   logic          rsp;
   logic          push;
   logic          issue;
   logic [CW:0]   occupancy;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Handshake decisions: pop to decode, accept response, and issue gating by reserved FIFO space.
   always_comb begin
      pop       = !stall_in && (count_q != '0);
      occupancy = (CW+1)'(count_q) - (CW+1)'(pop) + (CW+1)'(outstanding_q);
      issue     = !rst_in && !redirect_in
                  && (!outstanding_q || imem.imem_rvalid_in)
                  && (occupancy < (CW+1)'(BUF_DEPTH));
      rsp       = imem.imem_rvalid_in && outstanding_q;
      push      = rsp && !drop_q && !redirect_in;
   end

   // Next-state for fetch PC, in-flight tracking, FIFO pointers and the IF/ID register.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      req_pc_d      = req_pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      instr_d       = instr_q;
      pc_d          = pc_q;
      flush_d       = flush_q;

      if (issue) begin
         req_pc_d      = fetch_pc_q;
         outstanding_d = 1'b1;
      end else if (rsp) begin
         outstanding_d = 1'b0;
      end

      if (redirect_in) begin
         // Low two bits of the target are masked; a still-pending read must be thrown away.
         fetch_pc_d = redirect_pc_in & 32'hFFFF_FFFC;
         drop_d     = outstanding_q && !imem.imem_rvalid_in;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         instr_d    = NOP;
         flush_d    = 1'b1;
      end else begin
         if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (rsp) begin
            drop_d = 1'b0;
         end
         if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CW'(push) - CW'(pop);

         if (stall_in) begin
            instr_d = instr_q;
         end else if (count_q != '0) begin
            instr_d = fifo_q[rd_ptr_q].instr;
            pc_d    = fifo_q[rd_ptr_q].pc;
            flush_d = 1'b0;
         end else begin
            instr_d = NOP;
            flush_d = 1'b1;
         end
      end
   end

   // Control and IF/ID state, cleared immediately on reset.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         fetch_pc_q    <= RESET_PC;
         req_pc_q      <= RESET_PC;
         outstanding_q <= 1'b0;
         drop_q        <= 1'b0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         instr_q       <= NOP;
         pc_q          <= RESET_PC;
         flush_q       <= 1'b1;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         req_pc_q      <= req_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         instr_q       <= instr_d;
         pc_q          <= pc_d;
         flush_q       <= flush_d;
      end
   end

   // FIFO storage: entries are only meaningful between write and read pointer, so no reset needed.
   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= '{pc: req_pc_q, instr: imem.imem_rdata_in};
      end
   end

   assign imem.imem_req_out  = issue;
   assign imem.imem_addr_out = fetch_pc_q;
   assign instr_out          = instr_q;
   assign pc_out             = pc_q;
   assign flush_out          = flush_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: in-order memory with programmable latency plus a queue model.
// Latency: every cycle is checked at the falling edge against the model.
// Backpressure: stall and redirect driven by directed sequences.
module tb_instruction_fetch_stage;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        stall_in;
   logic        redirect_in;
   logic [31:0] redirect_pc_in;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        flush_out;

   instruction_fetch_stage_if imem ();

   instruction_fetch_stage #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .stall_in       (stall_in),
      .redirect_in    (redirect_in),
      .redirect_pc_in (redirect_pc_in),
      .imem           (imem),
      .instr_out      (instr_out),
      .pc_out         (pc_out),
      .flush_out      (flush_out)
   );

   always #5 clk_in = ~clk_in;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_n = 0;
   int lat   = 1;
   int inject_req  = 0;
   int inject_done = 0;

   // memory responder state
   typedef struct {
      int          due;
      logic [31:0] addr;
   } mreq_t;
   mreq_t mem_q[$];

   // behavioural model state
   logic [31:0] mq[$];
   logic        m_out   = 1'b0;
   logic        m_drop  = 1'b0;
   logic [31:0] m_fetch = RESET_PC;
   logic [31:0] m_req_pc = RESET_PC;
   logic [31:0] m_instr = NOP;
   logic [31:0] m_pc    = RESET_PC;
   logic        m_flush = 1'b1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA500_0000 ^ a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic model_step();
      logic pop;
      logic rsp;
      logic exp_req;
      int   occ;
      if (rst_in) begin
         chk("rst_instr", instr_out, NOP);
         chk("rst_pc", pc_out, RESET_PC);
         chk("rst_flush", {31'b0, flush_out}, 32'd1);
         chk("rst_req", {31'b0, imem.imem_req_out}, 32'd0);
         mq.delete();
         m_out   = 1'b0;
         m_drop  = 1'b0;
         m_fetch = RESET_PC;
         m_instr = NOP;
         m_pc    = RESET_PC;
         m_flush = 1'b1;
         return;
      end
      chk("instr_out", instr_out, m_instr);
      chk("pc_out", pc_out, m_pc);
      chk("flush_out", {31'b0, flush_out}, {31'b0, m_flush});
      pop     = !stall_in && (mq.size() != 0);
      occ     = mq.size() - (pop ? 1 : 0) + (m_out ? 1 : 0);
      exp_req = !redirect_in && (!m_out || imem.imem_rvalid_in) && (occ < DEPTH);
      chk("imem_req", {31'b0, imem.imem_req_out}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", imem.imem_addr_out, m_fetch);
      rsp = imem.imem_rvalid_in && m_out;
      if (redirect_in) begin
         mq.delete();
         m_instr = NOP;
         m_flush = 1'b1;
         m_drop  = m_out && !imem.imem_rvalid_in;
         m_out   = m_drop;
         m_fetch = {redirect_pc_in[31:2], 2'b00};
      end else begin
         if (!stall_in) begin
            if (mq.size() != 0) begin
               m_pc    = mq.pop_front();
               m_instr = mem_word(m_pc);
               m_flush = 1'b0;
            end else begin
               m_instr = NOP;
               m_flush = 1'b1;
            end
         end
         if (rsp) begin
            m_out = 1'b0;
            if (m_drop) m_drop = 1'b0;
            else        mq.push_back(m_req_pc);
         end
         if (exp_req) begin
            m_out    = 1'b1;
            m_req_pc = m_fetch;
            m_fetch  = m_fetch + 32'd4;
         end
      end
   endtask

   // one clock: compare/model at falling edge, memory response driven just after rising edge
   task automatic tick();
      mreq_t r;
      @(negedge clk_in);
      model_step();
      if (!rst_in && imem.imem_req_out) begin
         r.due  = cyc_n + lat;
         r.addr = imem.imem_addr_out;
         mem_q.push_back(r);
      end
      @(posedge clk_in);
      cyc_n++;
      #1;
      imem.imem_rvalid_in = 1'b0;
      imem.imem_rdata_in  = 32'h0;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc_n) begin
         imem.imem_rvalid_in = 1'b1;
         imem.imem_rdata_in  = mem_word(mem_q[0].addr);
         void'(mem_q.pop_front());
      end else if (inject_req != inject_done) begin
         inject_done++;
         imem.imem_rvalid_in = 1'b1;
         imem.imem_rdata_in  = 32'hDEAD_BEEF;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      rst_in              = 1'b1;
      stall_in            = 1'b0;
      redirect_in         = 1'b0;
      redirect_pc_in      = 32'h0;
      imem.imem_rvalid_in = 1'b0;
      imem.imem_rdata_in  = 32'h0;
      #2;
      chk("reset_instr", instr_out, NOP);
      chk("reset_flush", {31'b0, flush_out}, 32'd1);
      chk("reset_req", {31'b0, imem.imem_req_out}, 32'd0);
      tick();
      tick();

      // 1: stream at latency 1
      rst_in = 1'b0;
      #1;
      chk("t1_req0", {31'b0, imem.imem_req_out}, 32'd1);
      chk("t1_addr0", imem.imem_addr_out, 32'h0);
      tick(); #1;
      chk("t1_addr1", imem.imem_addr_out, 32'h4);
      chk("t1_flush1", {31'b0, flush_out}, 32'd1);
      tick(); #1;
      chk("t1_addr2", imem.imem_addr_out, 32'h8);
      chk("t1_flush2", {31'b0, flush_out}, 32'd1);
      tick(); #1;
      chk("t1_flush3", {31'b0, flush_out}, 32'd0);
      chk("t1_pc3", pc_out, 32'h0);
      chk("t1_instr3", instr_out, 32'hA500_0000);
      tick(); #1;
      chk("t1_pc4", pc_out, 32'h4);
      repeat (4) tick();

      // 2: four-cycle stall
      stall_in = 1'b1;
      #1;
      chk("t2_pc_at_stall", pc_out, 32'h14);
      repeat (3) tick();
      #1;
      chk("t2_req_off", {31'b0, imem.imem_req_out}, 32'd0);
      chk("t2_pc_hold", pc_out, 32'h14);
      chk("t2_instr_hold", instr_out, 32'hA500_0014);
      tick();
      stall_in = 1'b0;
      tick(); #1;
      chk("t2_pc_next", pc_out, 32'h18);
      tick(); #1;
      chk("t2_pc_next2", pc_out, 32'h1C);

      // 3: redirect with a read in flight at latency 3
      lat = 3;
      repeat (6) tick();
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (mem_q.size() != 0 && !imem.imem_rvalid_in) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("t3_inflight_found", {31'b0, found}, 32'd1);
      redirect_in    = 1'b1;
      redirect_pc_in = 32'h103;
      #1;
      chk("t3_req_gated", {31'b0, imem.imem_req_out}, 32'd0);
      tick();
      redirect_in = 1'b0;
      #1;
      chk("t3_flush", {31'b0, flush_out}, 32'd1);
      chk("t3_nop", instr_out, NOP);
      for (int i = 0; i < 10; i++) begin
         if (imem.imem_req_out) break;
         tick(); #1;
      end
      chk("t3_req_seen", {31'b0, imem.imem_req_out}, 32'd1);
      chk("t3_addr", imem.imem_addr_out, 32'h100);
      for (int i = 0; i < 20; i++) begin
         if (!flush_out) break;
         tick(); #1;
      end
      chk("t3_first_pc", pc_out, 32'h100);
      chk("t3_first_instr", instr_out, 32'hA500_0100);

      // 4 + 6: redirect under stall with full FIFO, then a stray response
      lat = 1;
      repeat (8) tick();
      stall_in = 1'b1;
      repeat (4) tick();
      redirect_in    = 1'b1;
      redirect_pc_in = 32'h200;
      inject_req++;
      #1;
      chk("t4_full_noreq", {31'b0, imem.imem_req_out}, 32'd0);
      tick();
      redirect_in = 1'b0;
      #1;
      chk("t4_flush", {31'b0, flush_out}, 32'd1);
      chk("t4_nop", instr_out, NOP);
      chk("t6_req", {31'b0, imem.imem_req_out}, 32'd1);
      chk("t6_addr", imem.imem_addr_out, 32'h200);
      tick(); #1;
      chk("t6_flush_stays", {31'b0, flush_out}, 32'd1);
      chk("t6_nop_stays", instr_out, NOP);
      tick();
      stall_in = 1'b0;
      tick(); #1;
      chk("t4_pc", pc_out, 32'h200);
      chk("t4_flush_clear", {31'b0, flush_out}, 32'd0);

      // 5: reset pulse mid-cycle with a read in flight at latency 3
      lat = 3;
      repeat (6) tick();
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (mem_q.size() != 0 && mem_q[0].due == cyc_n + 2) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("t5_inflight_found", {31'b0, found}, 32'd1);
      #1;
      rst_in = 1'b1;
      #1;
      chk("t5_instr", instr_out, NOP);
      chk("t5_pc", pc_out, RESET_PC);
      chk("t5_flush", {31'b0, flush_out}, 32'd1);
      chk("t5_req", {31'b0, imem.imem_req_out}, 32'd0);
      tick();
      tick();
      rst_in = 1'b0;
      #1;
      chk("t5_restart_req", {31'b0, imem.imem_req_out}, 32'd1);
      chk("t5_restart_addr", imem.imem_addr_out, RESET_PC);
      for (int i = 0; i < 20; i++) begin
         if (!flush_out) break;
         tick(); #1;
      end
      chk("t5_first_pc", pc_out, RESET_PC);
      chk("t5_first_instr", instr_out, 32'hA500_0000);
      tick(); #1;
      repeat (4) tick();
      tick(); #1;

      repeat (8) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
